// File: rtl/huc_multi_timer.sv
// ---------------------------------------------------------------------------
// huc_multi_timer
//
// NCH independent down-counting timers. Each channel has a reload register,
// a 2^DIV_W prescaler, periodic or one-shot mode, an interrupt enable and a
// pending flag. The channels share a small MMIO window.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high reset
//   clk_en    CPU clock enable; no state changes while low
//   cs_n      chip select, active-low
//   re, we    read / write strobes
//   ch_sel    channel select (out-of-range values hit nothing)
//   reg_sel   0 = reload (write) / counter (read), 1 = control, 2 = status
//   din       write data
//   dout      combinational read data, 0 when no read is active
//   irq_ack   per-channel pending clear pulses (qualified by clk_en)
//   irq_pend  per-channel pending flags
//   irq_n     registered active-low OR of (pend & ie) over all channels
// ---------------------------------------------------------------------------
module huc_multi_timer #(
   parameter int NCH   = 2,
   parameter int CNT_W = 7,
   parameter int DIV_W = 10,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             cs_n,
   input  logic             re,
   input  logic             we,
   input  logic [CH_W-1:0]  ch_sel,
   input  logic [1:0]       reg_sel,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   input  logic [NCH-1:0]   irq_ack,
   output logic [NCH-1:0]   irq_pend,
   output logic             irq_n
);

   localparam logic [1:0] REG_CNT  = 2'd0;
   localparam logic [1:0] REG_CTRL = 2'd1;
   localparam logic [1:0] REG_STAT = 2'd2;

   // Per-channel state
   logic [NCH-1:0]             en_q, oneshot_q, ie_q, pend_q;
   logic [NCH-1:0][CNT_W-1:0]  cnt_q, reload_q;
   logic [NCH-1:0][DIV_W-1:0]  div_q;
   logic                       irq_n_q;

   logic [NCH-1:0]             en_d, oneshot_d, ie_d, pend_d;
   logic [NCH-1:0][CNT_W-1:0]  cnt_d, reload_d;
   logic [NCH-1:0][DIV_W-1:0]  div_d;
   logic                       irq_n_d;

   // Per-channel events for the current cycle
   logic [NCH-1:0]             wr_ch, restart, tick, underflow, pend_clr;

   // Write data bits above the register widths have no storage.
   logic                       unused_din;
   assign unused_din = ^din;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // can leave one unassigned and infer a latch.
      en_d      = en_q;
      oneshot_d = oneshot_q;
      ie_d      = ie_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      reload_d  = reload_q;
      div_d     = div_q;
      wr_ch     = '0;
      restart   = '0;
      tick      = '0;
      underflow = '0;
      pend_clr  = '0;

      for (int i = 0; i < NCH; i++) begin
         wr_ch[i]     = clk_en & ~cs_n & we & (ch_sel == CH_W'(i));
         // Restart only on a 0->1 transition of en; re-writing en=1 is a no-op.
         restart[i]   = wr_ch[i] & (reg_sel == REG_CTRL) & din[0] & ~en_q[i];
         tick[i]      = clk_en & en_q[i] & (div_q[i] == '0);
         underflow[i] = tick[i] & (cnt_q[i] == '0);
         pend_clr[i]  = (clk_en & irq_ack[i]) |
                        (wr_ch[i] & (reg_sel == REG_STAT) & din[0]);

         // Prescaler free-runs (wrapping) while enabled.
         if (clk_en && en_q[i])
            div_d[i] = div_q[i] - DIV_W'(1);

         // The tick always sees the reload value from before this cycle.
         if (tick[i])
            cnt_d[i] = underflow[i] ? reload_q[i] : cnt_q[i] - CNT_W'(1);

         if (restart[i]) begin
            div_d[i] = '1;
            cnt_d[i] = reload_q[i];
         end

         if (wr_ch[i] && reg_sel == REG_CNT)
            reload_d[i] = din[CNT_W-1:0];

         if (wr_ch[i] && reg_sel == REG_CTRL) begin
            en_d[i]      = din[0];
            oneshot_d[i] = din[1];
            ie_d[i]      = din[2];
         end

         // A one-shot underflow stops the channel even if en is rewritten.
         if (underflow[i] && oneshot_q[i])
            en_d[i] = 1'b0;

         // Set beats clear.
         pend_d[i] = underflow[i] | (pend_q[i] & ~pend_clr[i]);
      end

      // Registered request tracks the next-state pend/ie.
      irq_n_d = ~|(pend_d & ie_d);
   end

   always_ff @(posedge clk) begin
      // NOTE: all state, including the per-channel arrays, is reset: the
      // timer must come up idle with ie set and the prescaler at all ones.
      if (reset) begin
         en_q      <= '0;
         oneshot_q <= '0;
         ie_q      <= '1;
         pend_q    <= '0;
         cnt_q     <= '0;
         reload_q  <= '0;
         div_q     <= '1;
         irq_n_q   <= 1'b1;
      end else begin
         // NOTE: non-blocking updates so every register samples the
         // pre-edge values computed above.
         en_q      <= en_d;
         oneshot_q <= oneshot_d;
         ie_q      <= ie_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         reload_q  <= reload_d;
         div_q     <= div_d;
         irq_n_q   <= irq_n_d;
      end
   end

   // Side-effect-free combinational read port.
   always_comb begin
      dout = '0;
      if (~cs_n && re && (int'(ch_sel) < NCH)) begin
         case (reg_sel)
            REG_CNT:  dout = 8'(cnt_q[ch_sel]);
            REG_CTRL: dout = {5'b0, ie_q[ch_sel], oneshot_q[ch_sel], en_q[ch_sel]};
            REG_STAT: dout = {7'b0, pend_q[ch_sel]};
            default:  dout = '0;
         endcase
      end
   end

   assign irq_pend = pend_q;
   assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_huc_multi_timer.sv
module tb_huc_multi_timer;

   localparam int NCH   = 2;
   localparam int CNT_W = 7;
   localparam int DIV_W = 10;
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int P     = 1 << DIV_W;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clk_en = 1'b0;
   logic             cs_n = 1'b1;
   logic             re = 1'b0;
   logic             we = 1'b0;
   logic [CH_W-1:0]  ch_sel = '0;
   logic [1:0]       reg_sel = '0;
   logic [7:0]       din = '0;
   logic [7:0]       dout;
   logic [NCH-1:0]   irq_ack = '0;
   logic [NCH-1:0]   irq_pend;
   logic             irq_n;

   huc_multi_timer #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .clk_en   (clk_en),
      .cs_n     (cs_n),
      .re       (re),
      .we       (we),
      .ch_sel   (ch_sel),
      .reg_sel  (reg_sel),
      .din      (din),
      .dout     (dout),
      .irq_ack  (irq_ack),
      .irq_pend (irq_pend),
      .irq_n    (irq_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- bus helpers ----------------
   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // n enabled cycles with clk_en toggling 0,1
   task automatic run_half(input int n);
      repeat (n) begin
         clk_en = 1'b0;
         run(1);
         clk_en = 1'b1;
         run(1);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      clk_en = 1'b0;
      run(1);
      reset  = 1'b0;
      clk_en = 1'b1;
   endtask

   task automatic bus_write(input int ch, input int rs, input logic [7:0] data, input bit ce = 1'b1);
      ch_sel  = CH_W'(ch);
      reg_sel = 2'(rs);
      din     = data;
      we      = 1'b1;
      cs_n    = 1'b0;
      clk_en  = ce;
      run(1);
      we      = 1'b0;
      cs_n    = 1'b1;
      clk_en  = 1'b1;
   endtask

   task automatic rd(input int ch, input int rs, output logic [7:0] d,
                     input bit rcs_n = 1'b0, input bit rre = 1'b1);
      ch_sel  = CH_W'(ch);
      reg_sel = 2'(rs);
      cs_n    = rcs_n;
      re      = rre;
      #1;
      d       = dout;
      cs_n    = 1'b1;
      re      = 1'b0;
   endtask

   task automatic chk_rd(input string name, input int ch, input int rs, input logic [7:0] exp);
      logic [7:0] d;
      rd(ch, rs, d);
      check(name, d, exp);
   endtask

   // ---------------- reference model ----------------
   // Time is kept as the number of enabled cycles since the last restart;
   // a tick falls on every P-th such cycle.
   int  m_cnt [NCH];
   int  m_rel [NCH];
   int  m_age [NCH];
   bit  m_en  [NCH];
   bit  m_os  [NCH];
   bit  m_ie  [NCH];
   bit  m_pend[NCH];
   bit  m_irq_n;

   task automatic model_step();
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_age[i] = 0;
            m_en[i] = 0; m_os[i] = 0; m_ie[i] = 1; m_pend[i] = 0;
         end
      end else if (clk_en) begin
         for (int i = 0; i < NCH; i++) begin
            bit wr, tck, under, clr, os_old;
            wr     = !cs_n && we && (int'(ch_sel) == i);
            tck    = m_en[i] && (m_age[i] % P == P - 1);
            under  = tck && (m_cnt[i] == 0);
            clr    = irq_ack[i] || (wr && reg_sel == 2 && din[0]);
            os_old = m_os[i];
            if (tck) m_cnt[i] = under ? m_rel[i] : m_cnt[i] - 1;
            if (m_en[i]) m_age[i]++;
            else if (wr && reg_sel == 1 && din[0]) begin
               m_age[i] = 0;
               m_cnt[i] = m_rel[i];
            end
            m_pend[i] = under || (m_pend[i] && !clr);
            if (wr && reg_sel == 0) m_rel[i] = int'(din) % (1 << CNT_W);
            if (wr && reg_sel == 1) begin
               m_en[i] = din[0]; m_os[i] = din[1]; m_ie[i] = din[2];
            end
            if (under && os_old) m_en[i] = 0;
         end
      end
      m_irq_n = 1;
      for (int i = 0; i < NCH; i++)
         if (m_pend[i] && m_ie[i]) m_irq_n = 0;
   endtask

   function automatic logic [7:0] model_dout();
      int c;
      c = int'(ch_sel);
      if (cs_n || !re || c >= NCH) return 8'h00;
      case (reg_sel)
         2'd0:    return 8'(m_cnt[c]);
         2'd1:    return {5'b0, m_ie[c], m_os[c], m_en[c]};
         2'd2:    return {7'b0, m_pend[c]};
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [NCH-1:0] model_pend();
      logic [NCH-1:0] p;
      for (int i = 0; i < NCH; i++) p[i] = m_pend[i];
      return p;
   endfunction

   // ---------------- register access table ----------------
   typedef struct {
      bit         wr;
      bit         ce;
      int         ch;
      int         rs;
      logic [7:0] wdata;
      bit         rcs_n;
      bit         rre;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] d;

   initial begin
      //             wr ce ch rs wdata  cs_n re  exp
      vecs.push_back('{0, 1, 0, 0, 8'h00, 0, 1, 8'h00});
      vecs.push_back('{0, 1, 0, 1, 8'h00, 0, 1, 8'h04});
      vecs.push_back('{0, 1, 0, 2, 8'h00, 0, 1, 8'h00});
      vecs.push_back('{0, 1, 0, 3, 8'h00, 0, 1, 8'h00});
      vecs.push_back('{0, 1, 1, 0, 8'h00, 0, 1, 8'h00});
      vecs.push_back('{0, 1, 1, 1, 8'h00, 0, 1, 8'h04});
      vecs.push_back('{0, 1, 1, 2, 8'h00, 0, 1, 8'h00});
      vecs.push_back('{0, 1, 1, 3, 8'h00, 0, 1, 8'h00});
      vecs.push_back('{1, 1, 0, 0, 8'hFF, 0, 1, 8'h00}); // reload write leaves counter
      vecs.push_back('{1, 1, 1, 1, 8'h06, 0, 1, 8'h06});
      vecs.push_back('{0, 1, 1, 1, 8'h00, 1, 1, 8'h00}); // cs_n high
      vecs.push_back('{0, 1, 1, 1, 8'h00, 0, 0, 8'h00}); // re low
      vecs.push_back('{1, 0, 1, 1, 8'h01, 0, 1, 8'h06}); // write with clk_en low ignored
      vecs.push_back('{1, 1, 1, 1, 8'hF8, 0, 1, 8'h00});
      vecs.push_back('{1, 1, 0, 3, 8'hFF, 0, 1, 8'h00}); // reserved
      vecs.push_back('{1, 1, 0, 2, 8'h01, 0, 1, 8'h00});
      vecs.push_back('{1, 1, 0, 1, 8'h05, 0, 1, 8'h05}); // restart ch0
      vecs.push_back('{0, 1, 0, 0, 8'h00, 0, 1, 8'h7F}); // counter = masked reload

      // ---- reset state and register table ----
      do_reset();
      check("reset irq_n", irq_n, 1'b1);
      check("reset irq_pend", irq_pend, '0);
      foreach (vecs[k]) begin
         if (vecs[k].wr) bus_write(vecs[k].ch, vecs[k].rs, vecs[k].wdata, vecs[k].ce);
         else run(1);
         rd(vecs[k].ch, vecs[k].rs, d, vecs[k].rcs_n, vecs[k].rre);
         check($sformatf("vec%0d dout", k), d, vecs[k].exp);
      end

      // ---- periodic ch0, reload 2 ----
      do_reset();
      bus_write(0, 0, 8'd2);
      bus_write(0, 1, 8'h05);
      chk_rd("per cnt@0", 0, 0, 8'd2);
      run(1023);  chk_rd("per cnt@1023", 0, 0, 8'd2);
      run(1);     chk_rd("per cnt@1024", 0, 0, 8'd1);
      run(1024);  chk_rd("per cnt@2048", 0, 0, 8'd0);
      check("per pend@2048", irq_pend, 2'b00);
      run(1023);  check("per pend@3071", irq_pend, 2'b00);
      check("per irq_n@3071", irq_n, 1'b1);
      run(1);     check("per pend@3072", irq_pend, 2'b01);
      check("per irq_n@3072", irq_n, 1'b0);
      chk_rd("per cnt@3072", 0, 0, 8'd2);
      run(3071);  chk_rd("per cnt@6143", 0, 0, 8'd0);
      run(1);     chk_rd("per cnt@6144", 0, 0, 8'd2);
      check("per pend@6144", irq_pend, 2'b01);

      // ---- one-shot ch1, reload 0 ----
      do_reset();
      bus_write(1, 0, 8'd0);
      bus_write(1, 1, 8'h07);
      run(1023);  check("os pend@1023", irq_pend, 2'b00);
      run(1);     check("os pend@1024", irq_pend, 2'b10);
      check("os irq_n@1024", irq_n, 1'b0);
      chk_rd("os ctrl", 1, 1, 8'h06);
      chk_rd("os cnt", 1, 0, 8'h00);
      irq_ack = 2'b10; run(1); irq_ack = '0;
      check("os ack pend", irq_pend, 2'b00);
      check("os ack irq_n", irq_n, 1'b1);
      run(2100);
      check("os no repend", irq_pend, 2'b00);
      chk_rd("os cnt held", 1, 0, 8'h00);

      // ---- set beats clear, status clear, clk_en gating of ack ----
      do_reset();
      bus_write(0, 0, 8'd0);
      bus_write(0, 1, 8'h05);
      run(1023);  check("sbc pend@1023", irq_pend, 2'b00);
      irq_ack = 2'b01; run(1); irq_ack = '0;
      check("sbc pend@1024", irq_pend, 2'b01);
      check("sbc irq_n@1024", irq_n, 1'b0);
      bus_write(0, 2, 8'h01);
      check("stat clr pend", irq_pend, 2'b00);
      check("stat clr irq_n", irq_n, 1'b1);
      run(1023);  check("sbc pend@2048", irq_pend, 2'b01);
      bus_write(0, 2, 8'hFE);
      check("stat write0 pend", irq_pend, 2'b01);
      clk_en = 1'b0; irq_ack = 2'b01; run(1);
      check("ack gated pend", irq_pend, 2'b01);
      clk_en = 1'b1; run(1); irq_ack = '0;
      check("ack pend", irq_pend, 2'b00);

      // ---- ie masking, re-enable does not restart ----
      do_reset();
      bus_write(0, 0, 8'd1);
      bus_write(0, 1, 8'h01);
      run(2048);
      check("ie0 pend", irq_pend, 2'b01);
      chk_rd("ie0 stat", 0, 2, 8'h01);
      check("ie0 irq_n", irq_n, 1'b1);
      bus_write(0, 1, 8'h05);
      check("ie1 irq_n", irq_n, 1'b0);
      chk_rd("ie1 cnt", 0, 0, 8'd1);
      run(1023);
      chk_rd("ie1 no restart", 0, 0, 8'd0);

      // ---- reset clears pend; stop/restart with 50% clk_en ----
      do_reset();
      check("rst irq_n", irq_n, 1'b1);
      check("rst pend", irq_pend, 2'b00);
      bus_write(0, 0, 8'd2);
      bus_write(0, 1, 8'h05);
      run_half(1023);
      chk_rd("half cnt@1023", 0, 0, 8'd2);
      clk_en = 1'b0; run(1);
      chk_rd("half gated tick", 0, 0, 8'd2);
      clk_en = 1'b1; run(1);
      chk_rd("half cnt@1024", 0, 0, 8'd1);
      run_half(500);
      bus_write(0, 1, 8'h04);
      chk_rd("stop ctrl", 0, 1, 8'h04);
      run_half(2000);
      chk_rd("stop frozen", 0, 0, 8'd1);
      check("stop pend", irq_pend, 2'b00);
      bus_write(0, 1, 8'h05);
      chk_rd("restart cnt", 0, 0, 8'd2);
      run_half(1023);
      chk_rd("restart cnt@1023", 0, 0, 8'd2);
      run_half(1);
      chk_rd("restart cnt@1024", 0, 0, 8'd1);
      run_half(300);
      reset = 1'b1; clk_en = 1'b0; run(1); reset = 1'b0; clk_en = 1'b1;
      chk_rd("midrst cnt", 0, 0, 8'd0);
      chk_rd("midrst ctrl", 0, 1, 8'h04);
      check("midrst pend", irq_pend, 2'b00);
      check("midrst irq_n", irq_n, 1'b1);

      // ---- randomized run against the model ----
      reset = 1'b1; clk_en = 1'b0; cs_n = 1'b1; we = 1'b0; re = 1'b0; irq_ack = '0;
      model_step();
      run(1);
      for (int k = 0; k < 20000; k++) begin
         reset   = ($urandom_range(0, 7999) == 0);
         clk_en  = ($urandom_range(0, 3) != 0);
         we      = ($urandom_range(0, 47) == 0);
         re      = 1'($urandom_range(0, 1));
         cs_n    = !(we || ($urandom_range(0, 1) == 1));
         ch_sel  = CH_W'($urandom_range(0, (1 << CH_W) - 1));
         reg_sel = 2'($urandom_range(0, 3));
         din     = 8'($urandom);
         if (reg_sel == 2'd0) din = 8'($urandom_range(0, 3));
         if (reg_sel == 2'd1) din[0] = ($urandom_range(0, 7) != 0);
         irq_ack = ($urandom_range(0, 31) == 0) ? NCH'($urandom) : '0;
         #1;
         check("rnd dout", dout, model_dout());
         model_step();
         run(1);
         check("rnd irq_pend", irq_pend, model_pend());
         check("rnd irq_n", irq_n, m_irq_n);
      end
      reset = 1'b0; we = 1'b0; cs_n = 1'b1; re = 1'b0; irq_ack = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
